result_merge3: RTL and testbench
================================

RESULT_MERGE3 -- requirements
Module: result_merge3

Interface
REQ-001 SHALL have parameter PKT_W, default 64: width of one result packet payload.
REQ-002 SHALL have parameter DEPTH, default 2: entries per source FIFO; legal values 2 and 4.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have port flush_i  input  1  recovery flush; discards all buffered and output-stage packets.
REQ-006 SHALL have ports in_valid_i[3]  input  3  per-source packet valid (0=simple, 1=complex, 2=FP).
REQ-007 SHALL have port in_pkt_i  input  3xPKT_W  per-source packet payload.
REQ-008 SHALL have port in_ready_o  output  3  per-source accept; a transfer occurs when valid and ready are both 1.
REQ-009 SHALL have port out_valid_o  output  1  merged packet valid.
REQ-010 SHALL have port out_pkt_o  output  PKT_W  merged packet payload.
REQ-011 SHALL have port out_src_o  output  2  source index of out_pkt_o.
REQ-012 SHALL have port out_ready_i  input  1  downstream accept.
REQ-013 SHALL have port busy_o  output  1  high when any FIFO is non-empty or out_valid_o is 1.

Function
REQ-014 SHALL keep one FIFO per source with DEPTH entries, in-order, and a count register of width clog2(DEPTH)+1.
REQ-015 SHALL drive in_ready_o[i] = !flush_i && (count[i] < DEPTH), combinationally from registered count.
REQ-016 SHALL NOT accept a push into a full FIFO even if that FIFO pops in the same cycle.
REQ-017 SHALL accept a simultaneous push and pop on a non-full FIFO, leaving count unchanged.
REQ-018 SHALL hold a registered output stage of out_valid_o, out_pkt_o and out_src_o.
REQ-019 SHALL load the output stage when (!out_valid_o || out_ready_i) and at least one FIFO is non-empty, popping exactly one FIFO.
REQ-020 SHALL clear out_valid_o when out_ready_i=1 and no FIFO is non-empty.
REQ-021 SHALL hold out_valid_o, out_pkt_o and out_src_o stable while out_valid_o=1 and out_ready_i=0.
REQ-022 SHALL choose the popped FIFO by round-robin:
  - search order rr_ptr, rr_ptr+1, rr_ptr+2, modulo 3;
  - on grant, rr_ptr becomes granted index + 1, modulo 3;
  - rr_ptr is unchanged when there is no grant.
REQ-023 SHALL have a minimum latency of 1 cycle: a packet accepted in cycle N appears on out_pkt_o in cycle N+1 if its FIFO was empty, it wins arbitration, and the output stage can load.
REQ-024 SHALL sustain a throughput of one packet per cycle when out_ready_i is held at 1.
REQ-025 SHALL preserve per-source order; there is no ordering guarantee across sources.
REQ-026 SHALL, on flush_i=1 in cycle N, do all of the following at the clock edge ending cycle N:
  - set all counts and pointers to 0;
  - set out_valid_o=0 and rr_ptr=0;
  - perform no push and no load in cycle N.
REQ-027 SHALL give flush_i priority over every push, pop and load in the same cycle.
REQ-028 SHALL compute busy_o combinationally from registered state.
REQ-029 SHALL treat out_pkt_o and out_src_o as don't-care while out_valid_o=0, but they SHALL NOT be X after reset.

Reset
REQ-030 SHALL, while reset=1, asynchronously set:
  - all FIFO counts and pointers to 0;
  - rr_ptr to 0;
  - out_valid_o to 0;
  - out_pkt_o to 0 and out_src_o to 0.
REQ-031 SHALL drive in_ready_o to 3'b111 and busy_o to 0 once reset deasserts, with flush_i=0.
REQ-032 SHALL, on reset asserted mid-transfer, discard all packets with no partial output.

Verification
REQ-033 SHALL cover single source: push 0xA5 on source 1 with out_ready_i=1 -> next cycle out_valid_o=1, out_pkt_o=0xA5, out_src_o=1.
REQ-034 SHALL cover contention: all three sources push P0, P1, P2 in the same cycle after reset with out_ready_i=1 -> outputs appear in order src 0, 1, 2 on consecutive cycles.
REQ-035 SHALL cover backpressure: out_ready_i=0 with DEPTH=2 and source 0 pushing 4 packets back-to-back -> in_ready_o[0]=0 after 3 packets are accepted (1 in the output stage, 2 in the FIFO); out_pkt_o stays stable; releasing out_ready_i drains all packets in order.
REQ-036 SHALL cover the full FIFO with a pop: count=DEPTH with a pop in the same cycle -> in_ready_o=0, no push; the next cycle has in_ready_o=1.
REQ-037 SHALL cover flush: FIFOs partly full and out_valid_o=1, assert flush_i for 1 cycle -> next cycle out_valid_o=0, busy_o=0, in_ready_o=3'b111; pushes offered during the flush cycle are lost.
REQ-038 SHALL cover async reset: assert reset between clock edges with packets buffered -> out_valid_o=0 immediately and all state is cleared.

Source files
------------

// File: rtl/result_merge3.sv
// rtl/result_merge3.sv - three-source round-robin result merge with per-source FIFOs
// An empty FIFO forwards a same-cycle push straight to the output stage for 1-cycle latency.
module result_merge3 #(
   parameter int PKT_W = 64,
   parameter int DEPTH = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               flush_i,
   input  logic [2:0]         in_valid_i,
   input  logic [3*PKT_W-1:0] in_pkt_i,
   output logic [2:0]         in_ready_o,
   output logic               out_valid_o,
   output logic [PKT_W-1:0]   out_pkt_o,
   output logic [1:0]         out_src_o,
   input  logic               out_ready_i,
   output logic               busy_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

   logic [PKT_W-1:0] mem_q [3][DEPTH];
   logic [AW-1:0]    wr_ptr_q [3];
   logic [AW-1:0]    rd_ptr_q [3];
   logic [CW-1:0]    count_q [3];
   logic [1:0]       rr_ptr_q;
   logic [1:0]       rr_ptr_d;
   logic             out_valid_q;
   logic [PKT_W-1:0] out_pkt_q;
   logic [1:0]       out_src_q;

   logic [2:0]       nonempty;
   logic [2:0]       push;
   logic [2:0]       pop;
   logic [2:0]       cand;
   logic [PKT_W-1:0] head [3];
   logic             grant_vld;
   logic [1:0]       grant_idx;
   logic             load_en;
   logic [2:0]       idx;

   always_comb begin
      nonempty   = '0;
      in_ready_o = '0;
      push       = '0;
      cand       = '0;
      for (int i = 0; i < 3; i++) begin
         nonempty[i]   = (count_q[i] != '0);
         in_ready_o[i] = !flush_i && (count_q[i] < FULL_C);
         push[i]       = in_valid_i[i] && in_ready_o[i];
         cand[i]       = nonempty[i] || push[i];
         head[i]       = nonempty[i] ? mem_q[i][rd_ptr_q[i]] : in_pkt_i[i*PKT_W +: PKT_W];
      end
   end

   // Round-robin search starting at rr_ptr, wrapping modulo 3.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = 2'd0;
      idx       = '0;
      for (int k = 0; k < 3; k++) begin
         idx = {1'b0, rr_ptr_q} + 3'(k);
         if (idx >= 3'd3) idx = idx - 3'd3;
         if (!grant_vld && cand[idx[1:0]]) begin
            grant_vld = 1'b1;
            grant_idx = idx[1:0];
         end
      end
      load_en  = !flush_i && (!out_valid_q || out_ready_i) && grant_vld;
      rr_ptr_d = (grant_idx == 2'd2) ? 2'd0 : grant_idx + 2'd1;
      pop      = '0;
      for (int i = 0; i < 3; i++) begin
         pop[i] = load_en && (grant_idx == 2'(i));
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (push[i]) mem_q[i][wr_ptr_q[i]] <= in_pkt_i[i*PKT_W +: PKT_W];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 3; i++) begin
            count_q[i]  <= '0;
            wr_ptr_q[i] <= '0;
            rd_ptr_q[i] <= '0;
         end
         rr_ptr_q    <= 2'd0;
         out_valid_q <= 1'b0;
         out_pkt_q   <= '0;
         out_src_q   <= 2'd0;
      end else if (flush_i) begin
         for (int i = 0; i < 3; i++) begin
            count_q[i]  <= '0;
            wr_ptr_q[i] <= '0;
            rd_ptr_q[i] <= '0;
         end
         rr_ptr_q    <= 2'd0;
         out_valid_q <= 1'b0;
      end else begin
         // A push and pop on an empty FIFO advance both pointers and leave count at 0.
         for (int i = 0; i < 3; i++) begin
            if (push[i]) wr_ptr_q[i] <= wr_ptr_q[i] + 1'b1;
            if (pop[i])  rd_ptr_q[i] <= rd_ptr_q[i] + 1'b1;
            if (push[i] && !pop[i])      count_q[i] <= count_q[i] + 1'b1;
            else if (pop[i] && !push[i]) count_q[i] <= count_q[i] - 1'b1;
         end
         if (load_en) begin
            out_valid_q <= 1'b1;
            out_pkt_q   <= head[grant_idx];
            out_src_q   <= grant_idx;
            rr_ptr_q    <= rr_ptr_d;
         end else if (out_ready_i) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign out_valid_o = out_valid_q;
   assign out_pkt_o   = out_pkt_q;
   assign out_src_o   = out_src_q;
   assign busy_o      = (|nonempty) || out_valid_q;

endmodule

// File: tb/tb_result_merge3.sv
// tb/tb_result_merge3.sv - bench for result_merge3 against a queue-based reference model
module tb_result_merge3;
   localparam int PKT_W = 64;
   localparam int DEPTH = 2;

   logic               clk = 1'b0;
   logic               reset;
   logic               flush_i;
   logic [2:0]         in_valid_i;
   logic [3*PKT_W-1:0] in_pkt_i;
   logic [2:0]         in_ready_o;
   logic               out_valid_o;
   logic [PKT_W-1:0]   out_pkt_o;
   logic [1:0]         out_src_o;
   logic               out_ready_i;
   logic               busy_o;

   always #5 clk = ~clk;

   result_merge3 #(.PKT_W(PKT_W), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .reset      (reset),
      .flush_i    (flush_i),
      .in_valid_i (in_valid_i),
      .in_pkt_i   (in_pkt_i),
      .in_ready_o (in_ready_o),
      .out_valid_o(out_valid_o),
      .out_pkt_o  (out_pkt_o),
      .out_src_o  (out_src_o),
      .out_ready_i(out_ready_i),
      .busy_o     (busy_o)
   );

   int checks = 0;
   int errors = 0;

   logic [PKT_W-1:0] mq [3][$];
   bit               m_vld;
   logic [PKT_W-1:0] m_pkt;
   int               m_src;
   int               m_rr;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 3; i++) mq[i].delete();
      m_vld = 1'b0;
      m_pkt = '0;
      m_src = 0;
      m_rr  = 0;
   endtask

   function automatic bit model_busy();
      return m_vld || (mq[0].size() > 0) || (mq[1].size() > 0) || (mq[2].size() > 0);
   endfunction

   task automatic do_reset();
      @(negedge clk);
      in_valid_i  = '0;
      flush_i     = 1'b0;
      reset       = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask

   // One clock cycle: drive, check combinational outputs, advance model, check registered outputs.
   task automatic step(input logic [2:0] v, input logic [63:0] p0, input logic [63:0] p1,
                       input logic [63:0] p2, input logic ordy, input logic fl);
      logic [2:0]  exp_rdy;
      logic [63:0] pk [3];
      int          g;
      int          id;
      pk[0] = p0; pk[1] = p1; pk[2] = p2;
      @(negedge clk);
      in_valid_i  = v;
      in_pkt_i    = {p2, p1, p0};
      out_ready_i = ordy;
      flush_i     = fl;
      #1;
      for (int i = 0; i < 3; i++) exp_rdy[i] = !fl && (mq[i].size() < DEPTH);
      chk("in_ready", 64'(in_ready_o), 64'(exp_rdy));
      chk("busy", 64'(busy_o), 64'(model_busy()));
      if (fl) begin
         for (int i = 0; i < 3; i++) mq[i].delete();
         m_vld = 1'b0;
         m_rr  = 0;
      end else begin
         for (int i = 0; i < 3; i++) if (v[i] && exp_rdy[i]) mq[i].push_back(pk[i]);
         if (!m_vld || ordy) begin
            g = -1;
            for (int k = 0; k < 3; k++) begin
               id = (m_rr + k) % 3;
               if (g < 0 && mq[id].size() > 0) g = id;
            end
            if (g >= 0) begin
               m_pkt = mq[g].pop_front();
               m_src = g;
               m_vld = 1'b1;
               m_rr  = (g + 1) % 3;
            end else begin
               m_vld = 1'b0;
            end
         end
      end
      @(posedge clk);
      #1;
      chk("out_valid", 64'(out_valid_o), 64'(m_vld));
      if (m_vld) begin
         chk("out_pkt", out_pkt_o, m_pkt);
         chk("out_src", 64'(out_src_o), 64'(m_src));
      end
   endtask

   initial begin
      reset       = 1'b1;
      flush_i     = 1'b0;
      in_valid_i  = '0;
      in_pkt_i    = '0;
      out_ready_i = 1'b0;
      model_reset();
      #1;
      chk("rst_out_valid", 64'(out_valid_o), 64'd0);
      chk("rst_out_pkt", out_pkt_o, 64'd0);
      chk("rst_out_src", 64'(out_src_o), 64'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rst_in_ready", 64'(in_ready_o), 64'b111);
      chk("rst_busy", 64'(busy_o), 64'd0);

      // Single source, 1-cycle latency.
      step(3'b010, 64'd0, 64'hA5, 64'd0, 1'b1, 1'b0);
      chk("single_valid", 64'(out_valid_o), 64'd1);
      chk("single_pkt", out_pkt_o, 64'hA5);
      chk("single_src", 64'(out_src_o), 64'd1);
      step(3'b000, 64'd0, 64'd0, 64'd0, 1'b1, 1'b0);

      // Contention right after reset: sources 0, 1, 2 in order.
      do_reset();
      step(3'b111, 64'h100, 64'h101, 64'h102, 1'b1, 1'b0);
      chk("cont_src0", 64'(out_src_o), 64'd0);
      step(3'b000, 64'd0, 64'd0, 64'd0, 1'b1, 1'b0);
      chk("cont_src1", 64'(out_src_o), 64'd1);
      step(3'b000, 64'd0, 64'd0, 64'd0, 1'b1, 1'b0);
      chk("cont_src2", 64'(out_src_o), 64'd2);
      step(3'b000, 64'd0, 64'd0, 64'd0, 1'b1, 1'b0);

      // Backpressure on source 0, then full FIFO with a same-cycle pop.
      do_reset();
      step(3'b001, 64'hB0, 64'd0, 64'd0, 1'b0, 1'b0);
      step(3'b001, 64'hB1, 64'd0, 64'd0, 1'b0, 1'b0);
      step(3'b001, 64'hB2, 64'd0, 64'd0, 1'b0, 1'b0);
      chk("bp_ready0_low", 64'(in_ready_o[0]), 64'd0);
      step(3'b001, 64'hB3, 64'd0, 64'd0, 1'b0, 1'b0);
      chk("bp_pkt_stable", out_pkt_o, 64'hB0);
      step(3'b001, 64'hB3, 64'd0, 64'd0, 1'b1, 1'b0);
      chk("fullpop_pkt", out_pkt_o, 64'hB1);
      chk("fullpop_ready_next", 64'(in_ready_o[0]), 64'd1);
      step(3'b001, 64'hB3, 64'd0, 64'd0, 1'b1, 1'b0);
      chk("drain_b2", out_pkt_o, 64'hB2);
      step(3'b000, 64'd0, 64'd0, 64'd0, 1'b1, 1'b0);
      chk("drain_b3", out_pkt_o, 64'hB3);
      step(3'b000, 64'd0, 64'd0, 64'd0, 1'b1, 1'b0);

      // Flush with FIFOs partly full and the output stage loaded.
      step(3'b111, 64'hC0, 64'hC1, 64'hC2, 1'b0, 1'b0);
      step(3'b110, 64'hC3, 64'hC4, 64'hC5, 1'b0, 1'b0);
      step(3'b111, 64'hD0, 64'hD1, 64'hD2, 1'b0, 1'b1);
      @(negedge clk);
      flush_i    = 1'b0;
      in_valid_i = '0;
      #1;
      chk("flush_valid", 64'(out_valid_o), 64'd0);
      chk("flush_busy", 64'(busy_o), 64'd0);
      chk("flush_ready", 64'(in_ready_o), 64'b111);
      step(3'b000, 64'd0, 64'd0, 64'd0, 1'b1, 1'b0);

      // Asynchronous reset between edges with packets buffered.
      step(3'b111, 64'hE0, 64'hE1, 64'hE2, 1'b0, 1'b0);
      step(3'b111, 64'hE3, 64'hE4, 64'hE5, 1'b0, 1'b0);
      @(negedge clk);
      in_valid_i = '0;
      #2;
      reset = 1'b1;
      #1;
      chk("arst_valid", 64'(out_valid_o), 64'd0);
      chk("arst_busy", 64'(busy_o), 64'd0);
      chk("arst_ready", 64'(in_ready_o), 64'b111);
      model_reset();
      @(negedge clk);
      reset = 1'b0;
      step(3'b000, 64'd0, 64'd0, 64'd0, 1'b1, 1'b0);

      // Randomised traffic against the model.
      for (int n = 0; n < 400; n++) begin
         step(3'($urandom_range(0, 7)),
              {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
              ($urandom_range(0, 9) < 7), ($urandom_range(0, 39) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
